// File: rtl/hazard3_timer_cmp_sequencer_pkg.sv
// Shared timer register map and sequencer definitions.
// Contents:
//   TIMER_* offsets   APB offsets of the timer registers
//   seq_state_t       sequencer FSM state encoding
//   STEP_*            write-step indices within one compare update
//   cmp_addr()        address of a hart's mtimecmp low/high word
package hazard3_timer_cmp_sequencer_pkg;

    localparam logic [15:0] TIMER_CTRL      = 16'h0000;
    localparam logic [15:0] TIMER_MTIME     = 16'h0008;
    localparam logic [15:0] TIMER_MTIMEH    = 16'h000c;
    localparam logic [15:0] TIMER_MTIMECMP  = 16'h0010;
    localparam logic [15:0] TIMER_MTIMECMPH = 16'h0014;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_FIN    = 2'd3
    } seq_state_t;

    // Step 0 parks the low word at all-ones so the compare can never
    // transiently match while the high word is being replaced.
    localparam logic [1:0] STEP_ARM = 2'd0;
    localparam logic [1:0] STEP_HI  = 2'd1;
    localparam logic [1:0] STEP_LO  = 2'd2;

    // Each hart owns an 8-byte compare pair starting at base.
    function automatic logic [15:0] cmp_addr(input logic [15:0] base,
                                             input logic [1:0]  hart,
                                             input logic        hi);
        return base + {11'b0, hart, 3'b000} + (hi ? 16'd4 : 16'd0);
    endfunction

endpackage

// File: rtl/hazard3_rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   req         request vector, one bit per requester
//   advance     grant was taken; move priority past the winner
//   grant       one-hot grant (all zero when no request)
//   grant_idx   binary index of the granted requester
module hazard3_rr_arbiter
    import hazard3_timer_cmp_sequencer_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N-1:0]                      req,
    input  logic                              advance,
    output logic [N-1:0]                      grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic          found;

    // Scan starting at ptr; the first requester encountered wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found        = 1'b1;
                grant[cand]  = 1'b1;
                grant_idx    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/hazard3_timer_cmp_sequencer.sv
// Serialises per-hart mtimecmp updates onto the timer's APB port.
// Each update is three writes: LO<=all-ones, HI<=data[63:32], LO<=data[31:0].
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_data  per-hart update request and 64-bit compare value
//   req_ready           one-hot accept strobe (combinational in IDLE)
//   done / err          one-cycle completion / pslverr-abort pulse per hart
//   paddr..pwdata       APB master outputs; pready/pslverr APB inputs
//
// state   | meaning
// IDLE    | waiting for a request; grants the round-robin winner
// SETUP   | APB setup phase for the current step
// ACCESS  | APB access phase, held until pready
// FIN     | pulse done or err for the latched hart
module hazard3_timer_cmp_sequencer
    import hazard3_timer_cmp_sequencer_pkg::*;
#(
    parameter int          N_HARTS  = 2,
    parameter logic [15:0] CMP_BASE = 16'h0010
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_HARTS-1:0]     req_valid,
    input  logic [64*N_HARTS-1:0]  req_data,
    output logic [N_HARTS-1:0]     req_ready,
    output logic [N_HARTS-1:0]     done,
    output logic [N_HARTS-1:0]     err,
    output logic [15:0]            paddr,
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [31:0]            pwdata,
    input  logic                   pready,
    input  logic                   pslverr
);

    localparam int IW = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

    seq_state_t        state;
    seq_state_t        state_next;
    logic [1:0]        step;
    logic              err_flag;
    logic [IW-1:0]     idx;
    logic [63:0]       data_q;
    logic [N_HARTS-1:0] grant;
    logic [IW-1:0]     grant_idx;
    logic              accept;

    assign accept = (state == ST_IDLE) && !rst && (|req_valid);

    hazard3_rr_arbiter #(.N(N_HARTS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (pready) begin
                    if (pslverr || step == STEP_LO) state_next = ST_FIN;
                    else                            state_next = ST_SETUP;
                end
            end
            ST_FIN:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        psel      = 1'b0;
        penable   = 1'b0;
        req_ready = '0;
        done      = '0;
        err       = '0;
        case (state)
            ST_IDLE:   req_ready = accept ? grant : '0;
            ST_SETUP:  psel = 1'b1;
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            ST_FIN: begin
                if (err_flag) err[idx]  = 1'b1;
                else          done[idx] = 1'b1;
            end
            default: ;
        endcase
        pwrite = psel;
    end

    // paddr/pwdata are loaded on entry to SETUP so they hold through
    // ACCESS and keep their last value in IDLE/FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            step     <= STEP_ARM;
            err_flag <= 1'b0;
            idx      <= '0;
            data_q   <= '0;
            paddr    <= '0;
            pwdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        idx      <= grant_idx;
                        data_q   <= req_data[{grant_idx, 6'b0} +: 64];
                        step     <= STEP_ARM;
                        err_flag <= 1'b0;
                        paddr    <= cmp_addr(CMP_BASE, 2'(grant_idx), 1'b0);
                        pwdata   <= 32'hFFFF_FFFF;
                    end
                end
                ST_ACCESS: begin
                    if (pready) begin
                        if (pslverr) begin
                            err_flag <= 1'b1;
                        end else if (step != STEP_LO) begin
                            step <= step + 2'd1;
                            if (step == STEP_ARM) begin
                                paddr  <= cmp_addr(CMP_BASE, 2'(idx), 1'b1);
                                pwdata <= data_q[63:32];
                            end else begin
                                paddr  <= cmp_addr(CMP_BASE, 2'(idx), 1'b0);
                                pwdata <= data_q[31:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard3_timer_cmp_sequencer.sv
module tb_hazard3_timer_cmp_sequencer;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [64*N-1:0]   req_data;
    logic [N-1:0]      req_ready, done, err;
    logic [15:0]       paddr;
    logic              psel, penable, pwrite;
    logic [31:0]       pwdata;
    logic              pready, pslverr;

    hazard3_timer_cmp_sequencer #(.N_HARTS(N), .CMP_BASE(16'h0010)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .done(done), .err(err), .paddr(paddr),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [N-1:0]  pending;
    logic [63:0]   pdata [N];
    int            ptr;
    bit            active;
    int            act_idx;
    bit            act_err;
    int            fin_cycle;
    int            cycle;
    logic [47:0]   exp_q [$];
    int            cur_waits, cur_err_at;
    bit            cfg_random;
    int            fix_waits, fix_err_at;
    int            write_no, access_wait;
    logic [15:0]   setup_addr;
    logic [31:0]   setup_data;
    int            rst_at_write;
    bit            rst_check;

    function automatic int rr_pick(input logic [N-1:0] p, input int start);
        for (int k = 0; k < N; k++) begin
            if (p[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [15:0] lo_of(input int h);
        return 16'(16'h0010 + 8 * h);
    endfunction

    task automatic step_cycle();
        logic [N-1:0] exp_rr, exp_done, exp_err;
        logic [47:0]  e;
        int           w, nw;
        @(negedge clk);
        cycle++;
        if (rst_check) rst = 1'b0;
        req_valid = pending;
        for (int h = 0; h < N; h++) req_data[64*h +: 64] = pdata[h];
        #1;
        check_val("pwrite_eq_psel", pwrite, psel);
        if (!active) check_val("idle_psel", psel, 1'b0);
        if (rst_check) begin
            check_val("rst_psel", psel, 1'b0);
            check_val("rst_penable", penable, 1'b0);
            check_val("rst_paddr", paddr, 16'h0);
            check_val("rst_pwdata", pwdata, 32'h0);
            rst_check = 1'b0;
        end
        exp_rr = '0;
        w = -1;
        if (!rst && !active && pending != '0) begin
            w = rr_pick(pending, ptr);
            exp_rr[w] = 1'b1;
        end
        check_val("req_ready", req_ready, exp_rr);
        exp_done = '0;
        exp_err  = '0;
        if (active && cycle == fin_cycle) begin
            if (act_err) exp_err[act_idx] = 1'b1;
            else         exp_done[act_idx] = 1'b1;
        end
        check_val("done", done, exp_done);
        check_val("err", err, exp_err);
        if (active && cycle == fin_cycle) begin
            check_val("fin_psel", psel, 1'b0);
            active = 1'b0;
        end
        if (w >= 0) begin
            active  = 1'b1;
            act_idx = w;
            ptr     = (w + 1) % N;
            if (cfg_random) begin
                cur_waits  = $urandom_range(0, 2);
                cur_err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end else begin
                cur_waits  = fix_waits;
                cur_err_at = fix_err_at;
            end
            act_err   = (cur_err_at != 0);
            nw        = act_err ? cur_err_at : 3;
            fin_cycle = cycle + nw * (2 + cur_waits) + 1;
            exp_q.delete();
            exp_q.push_back({lo_of(w), 32'hFFFF_FFFF});
            if (nw >= 2) exp_q.push_back({16'(lo_of(w) + 16'd4), pdata[w][63:32]});
            if (nw >= 3) exp_q.push_back({lo_of(w), pdata[w][31:0]});
            pending[w]  = 1'b0;
            pdata[w]    = {$urandom, $urandom};
            write_no    = 1;
            access_wait = 0;
        end
        // APB completer model
        pready  = 1'b0;
        pslverr = 1'b0;
        if (psel && !penable) begin
            setup_addr  = paddr;
            setup_data  = pwdata;
            access_wait = 0;
        end else if (psel && penable) begin
            check_val("access_paddr_stable", paddr, setup_addr);
            check_val("access_pwdata_stable", pwdata, setup_data);
            if (rst_at_write != 0 && write_no == rst_at_write) begin
                rst          = 1'b1;
                rst_check    = 1'b1;
                rst_at_write = 0;
                active       = 1'b0;
                exp_q.delete();
                ptr          = 0;
            end else if (access_wait < cur_waits) begin
                access_wait++;
            end else begin
                pready  = 1'b1;
                pslverr = (write_no == cur_err_at);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_write", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("wr_addr", paddr, e[47:32]);
                    check_val("wr_data", pwdata, e[31:0]);
                end
                write_no++;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((active || pending != '0) && n < budget) begin
            step_cycle();
            n++;
        end
        if (active || pending != '0) check_val("drain_timeout", 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; pready = 1'b0; pslverr = 1'b0;
        req_valid = '0; req_data = '0;
        pending = '0; ptr = 0; active = 1'b0; act_idx = 0; act_err = 1'b0;
        fin_cycle = -1; cycle = 0; cur_waits = 0; cur_err_at = 0;
        cfg_random = 1'b0; fix_waits = 0; fix_err_at = 0;
        write_no = 0; access_wait = 0; setup_addr = '0; setup_data = '0;
        rst_at_write = 0; rst_check = 1'b0;
        for (int h = 0; h < N; h++) pdata[h] = '0;

        // reset state
        repeat (3) step_cycle();
        check_val("reset_psel", psel, 1'b0);
        check_val("reset_penable", penable, 1'b0);
        check_val("reset_pwrite", pwrite, 1'b0);
        check_val("reset_paddr", paddr, 16'h0);
        check_val("reset_pwdata", pwdata, 32'h0);
        rst = 1'b0;

        // single request, zero wait states
        pdata[0] = 64'h0000_0001_0000_0100;
        pending  = 3'b001;
        drain(50);

        // simultaneous request, then hart0 re-requests while hart1 is pending
        pdata[0] = {$urandom, $urandom};
        pdata[1] = {$urandom, $urandom};
        pending  = 3'b011;
        step_cycle();
        pending[0] = 1'b1;
        pdata[0]   = {$urandom, $urandom};
        drain(100);

        // wait states on every access
        fix_waits = 3;
        pdata[2]  = {$urandom, $urandom};
        pending   = 3'b100;
        drain(100);

        // slave error on the second write, then a clean update
        fix_waits  = 0;
        fix_err_at = 2;
        pdata[0]   = {$urandom, $urandom};
        pending    = 3'b001;
        drain(50);
        fix_err_at = 0;
        pdata[1]   = {$urandom, $urandom};
        pending    = 3'b010;
        drain(50);

        // reset during the access phase of the second write
        rst_at_write = 2;
        pdata[1]     = {$urandom, $urandom};
        pending      = 3'b010;
        drain(50);
        step_cycle();
        pdata[0] = {$urandom, $urandom};
        pdata[1] = {$urandom, $urandom};
        pending  = 3'b011;
        drain(100);

        // randomized traffic
        cfg_random = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step_cycle();
            if ($urandom_range(0, 2) == 0) begin
                int h;
                h = $urandom_range(0, N - 1);
                if (!pending[h]) begin
                    pdata[h]   = {$urandom, $urandom};
                    pending[h] = 1'b1;
                end
            end
        end
        drain(1000);
        repeat (3) step_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
